// File: rtl/dcs_pkg.sv
// Shared types and constants for the DCS slow-control router: parser states,
// UDP header layout and the channel-mask byte count helper.
package dcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_MASK = 3'd2,
    ST_PASS = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

  localparam int UDP_HDR_BYTES = 8;

  // Byte offsets inside the 8-byte UDP header
  localparam logic [2:0] HDR_SRC_HI  = 3'd0;
  localparam logic [2:0] HDR_SRC_LO  = 3'd1;
  localparam logic [2:0] HDR_DST_HI  = 3'd2;
  localparam logic [2:0] HDR_DST_LO  = 3'd3;
  localparam logic [2:0] HDR_LEN_HI  = 3'd4;
  localparam logic [2:0] HDR_LEN_LO  = 3'd5;
  localparam logic [2:0] HDR_CSUM_HI = 3'd6;
  localparam logic [2:0] HDR_CSUM_LO = 3'd7;

  function automatic int mask_bytes(input int nch);
    return (nch + 7) / 8;
  endfunction

endpackage

// File: rtl/dcs_pkt_stats.sv
// Accepted/dropped datagram counters; each strobe adds one, both may fire in
// the same cycle, and the counters wrap naturally.
module dcs_pkt_stats
  import dcs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             dcs_rx_clk,
  input  logic             reset,
  input  logic             pkt_inc,
  input  logic             drop_inc,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  always_ff @(posedge dcs_rx_clk) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_inc)  pkt_cnt  <= pkt_cnt + 1'b1;
      if (drop_inc) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcs_cmd_router.sv
// UDP slow-control router: filters on destination port, extracts the channel
// mask and fans payload out to NCH channels. Optional length check: DCS_CMD_ROUTER_LEN_CHK_EN.
//
// state | meaning
// IDLE  | between datagrams, waiting for udp_rx_dv
// HDR   | collecting UDP header bytes 1..7
// MASK  | shifting in the MB-byte channel mask, MSB first
// PASS  | forwarding payload with dcs_rx_dv = mask
// SKIP  | discarding the rest of a datagram until udp_rx_dv falls
module dcs_cmd_router
  import dcs_pkg::*;
#(
  parameter int          NCH       = 41,
  parameter logic [15:0] SC_PORT   = 16'h1001,
  parameter logic [15:0] PORT_MASK = 16'hFFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             dcs_rx_clk,
  input  logic             reset,
  input  logic [7:0]       udp_rxd,
  input  logic             udp_rx_dv,
  output logic [7:0]       dcs_rxd,
  output logic [NCH-1:0]   dcs_rx_dv,
  output logic             dcs_rx_sof,
  output logic             dcs_rx_done,
  output logic [15:0]      udp_rx_src_port,
  output logic [15:0]      udp_rx_dst_port,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int         MB        = mask_bytes(NCH);
  localparam logic [2:0] MASK_LAST = 3'(MB - 1);

  state_e         state;
  logic [2:0]     idx;
  logic           dv_q;
  logic           first;
  logic [NCH-1:0] mask_sr;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] mask_new;
  logic           port_ok;
  logic           pkt_inc;
  logic           drop_inc;

  // Bits shifted above NCH-1 fall off the top, which discards unused mask bits
  assign mask_new = NCH'({mask_sr, udp_rxd});
  assign port_ok  = ((udp_rx_dst_port ^ SC_PORT) & PORT_MASK) == 16'h0000;

  always_comb begin
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (!reset) begin
      pkt_inc = (state == ST_PASS) && !udp_rx_dv;
      unique case (state)
        ST_HDR:  drop_inc = !udp_rx_dv || ((idx == HDR_CSUM_LO) && !port_ok);
        ST_MASK: drop_inc = !udp_rx_dv || ((idx == MASK_LAST) && (mask_new == '0));
        default: drop_inc = 1'b0;
      endcase
    end
  end

  // dv_q is sampled through reset so a datagram already in flight is skipped
  always_ff @(posedge dcs_rx_clk) begin
    dv_q <= udp_rx_dv;
  end

  always_ff @(posedge dcs_rx_clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      first           <= 1'b0;
      mask_sr         <= '0;
      mask            <= '0;
      dcs_rxd         <= '0;
      dcs_rx_dv       <= '0;
      dcs_rx_sof      <= 1'b0;
      dcs_rx_done     <= 1'b0;
      udp_rx_src_port <= '0;
      udp_rx_dst_port <= '0;
    end else begin
      dcs_rxd     <= udp_rxd;
      dcs_rx_dv   <= '0;
      dcs_rx_sof  <= 1'b0;
      dcs_rx_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (udp_rx_dv) begin
            if (dv_q) begin
              state <= ST_SKIP;
            end else begin
              udp_rx_src_port[15:8] <= udp_rxd;
              idx                   <= 3'd1;
              state                 <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (!udp_rx_dv) begin
            state <= ST_IDLE;
          end else begin
            unique case (idx)
              HDR_SRC_LO: udp_rx_src_port[7:0]  <= udp_rxd;
              HDR_DST_HI: udp_rx_dst_port[15:8] <= udp_rxd;
              HDR_DST_LO: udp_rx_dst_port[7:0]  <= udp_rxd;
              default: ;
            endcase
            idx <= idx + 3'd1;
            if (idx == HDR_CSUM_LO) begin
              idx   <= '0;
              state <= port_ok ? ST_MASK : ST_SKIP;
            end
          end
        end
        ST_MASK: begin
          if (!udp_rx_dv) begin
            state <= ST_IDLE;
          end else begin
            mask_sr <= mask_new;
            idx     <= idx + 3'd1;
            if (idx == MASK_LAST) begin
              if (mask_new != '0) begin
                mask  <= mask_new;
                first <= 1'b1;
                state <= ST_PASS;
              end else begin
                state <= ST_SKIP;
              end
            end
          end
        end
        ST_PASS: begin
          if (udp_rx_dv) begin
            dcs_rx_dv  <= mask;
            dcs_rx_sof <= first;
            first      <= 1'b0;
          end else begin
            dcs_rx_done <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (!udp_rx_dv) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DCS_CMD_ROUTER_LEN_CHK_EN
  localparam logic [15:0] LEN_MIN = 16'(UDP_HDR_BYTES + MB);

  logic [15:0] byte_cnt;
  logic [15:0] len_field;

  always_ff @(posedge dcs_rx_clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      len_field <= '0;
      pkt_err   <= 1'b0;
    end else begin
      pkt_err <= 1'b0;
      if (udp_rx_dv) begin
        byte_cnt <= (state == ST_IDLE) ? 16'd1 : byte_cnt + 16'd1;
      end
      if ((state == ST_HDR) && udp_rx_dv && (idx == HDR_LEN_HI)) len_field[15:8] <= udp_rxd;
      if ((state == ST_HDR) && udp_rx_dv && (idx == HDR_LEN_LO)) len_field[7:0]  <= udp_rxd;
      if (pkt_inc) pkt_err <= (byte_cnt != len_field) || (len_field < LEN_MIN);
    end
  end
`else
  assign pkt_err = 1'b0;
`endif

  dcs_pkt_stats #(.CNT_W(CNT_W)) u_stats (
    .dcs_rx_clk (dcs_rx_clk),
    .reset      (reset),
    .pkt_inc    (pkt_inc),
    .drop_inc   (drop_inc),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

endmodule
